sc_frequencymeter: RTL and testbench

Gated-window frequency meter; the measuring end of the square-wave tone generator.
- Counts rising edges of an asynchronous square-wave input over a fixed window of GATE_CYCLES clock cycles, then publishes the count with a one-cycle valid pulse.
- With the default 1 s window at 50 MHz, the count is the input frequency in Hz.
- Used to check generator output (e.g. 440 Hz) on the board and in loopback benches.

---
 rtl/sc_frequency_pkg.sv | 14 +
 rtl/sc_edge_sync.sv | 24 ++
 rtl/sc_frequencymeter.sv | 166 ++++++++++++++++
 tb/tb_sc_frequencymeter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_frequency_pkg.sv
// Shared constants and state type for the tone generator / frequency meter pair.
// Gate counter width and the default 50 MHz / A4 operating point live here.
package sc_frequency_pkg;

  localparam int unsigned CLOCK_50_HZ = 50_000_000;
  localparam int unsigned TONE_A4_HZ  = 440;
  localparam int unsigned GATE_W      = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } fm_state_e;

endpackage

// File: rtl/sc_edge_sync.sv
// Three-flop synchronizer with a rising-edge pulse taken from the last two stages.
// Reset value is configurable so a resting-high input never produces a false edge.
module sc_edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sc_frequencymeter.sv
// Gated-window frequency meter: counts input rising edges over GATE_CYCLES clocks.
// Optional window-match flag is built when SC_FREQUENCYMETER_MATCH_EN is defined.
module sc_frequencymeter
  import sc_frequency_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 28,
  parameter int unsigned GATE_CYCLES = CLOCK_50_HZ,
  parameter int unsigned FREQUENCY   = TONE_A4_HZ,
  parameter int unsigned TOLERANCE   = 2
) (
  input  logic                   SC_FREQUENCYMETER_CLOCK_50,
  input  logic                   SC_FREQUENCYMETER_RESET_InHigh,
  input  logic                   SC_FREQUENCYMETER_enable_InHigh,
  input  logic                   SC_FREQUENCYMETER_signal_In,
  output logic [COUNT_WIDTH-1:0] SC_FREQUENCYMETER_data_OutBUS,
  output logic                   SC_FREQUENCYMETER_valid_OutHigh,
  output logic                   SC_FREQUENCYMETER_overflow_OutHigh
`ifdef SC_FREQUENCYMETER_MATCH_EN
  ,
  output logic                   SC_FREQUENCYMETER_match_OutHigh
`endif
);

  localparam logic [GATE_W-1:0] GATE_LAST =
    GATE_W'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 4) begin : g_gate_chk
    $error("GATE_CYCLES must be at least 4");
  end

  if (FREQUENCY + TOLERANCE >= 2 ** (COUNT_WIDTH + 1)) begin : g_band_chk
    $error("match band exceeds comparator range");
  end

  logic clk;
  logic rst;
  logic en;
  logic edge_w;

  assign clk = SC_FREQUENCYMETER_CLOCK_50;
  assign rst = SC_FREQUENCYMETER_RESET_InHigh;
  assign en  = SC_FREQUENCYMETER_enable_InHigh;

  sc_edge_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(SC_FREQUENCYMETER_signal_In),
    .edge_o (edge_w)
  );

  fm_state_e              state_q, state_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   wovf_q, wovf_d;
  logic [COUNT_WIDTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   match_q, match_d;

  logic                   last_w;
  logic                   sat_w;
  logic [COUNT_WIDTH-1:0] res_w;

  assign last_w = (gate_q == GATE_LAST);
  assign sat_w  = edge_w & (&cnt_q);
  assign res_w  = (edge_w && !sat_w) ?
                  cnt_q + COUNT_WIDTH'(1) : cnt_q;

`ifdef SC_FREQUENCYMETER_MATCH_EN
  localparam int unsigned LO_I =
    (FREQUENCY > TOLERANCE) ? FREQUENCY - TOLERANCE : 0;
  localparam int unsigned HI_I = FREQUENCY + TOLERANCE;
  localparam logic [COUNT_WIDTH:0] MATCH_LO =
    (COUNT_WIDTH + 1)'(LO_I);
  localparam logic [COUNT_WIDTH:0] MATCH_HI =
    (COUNT_WIDTH + 1)'(HI_I);

  logic in_band_w;
  assign in_band_w = ({1'b0, res_w} >= MATCH_LO) &&
                     ({1'b0, res_w} <= MATCH_HI);
`endif

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    wovf_d  = wovf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    match_d = match_q;
    unique case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        wovf_d = 1'b0;
        if (en) begin
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        if (last_w) begin
          // window closes regardless of enable on its final cycle
          data_d  = res_w;
          ovf_d   = wovf_q | sat_w;
          valid_d = 1'b1;
`ifdef SC_FREQUENCYMETER_MATCH_EN
          match_d = in_band_w & ~(wovf_q | sat_w);
`endif
          gate_d  = '0;
          cnt_d   = '0;
          wovf_d  = 1'b0;
          state_d = en ? ST_GATE : ST_IDLE;
        end else if (!en) begin
          gate_d  = '0;
          cnt_d   = '0;
          wovf_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          cnt_d  = res_w;
          wovf_d = wovf_q | sat_w;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      cnt_q   <= '0;
      wovf_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      wovf_q  <= wovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign SC_FREQUENCYMETER_data_OutBUS      = data_q;
  assign SC_FREQUENCYMETER_valid_OutHigh    = valid_q;
  assign SC_FREQUENCYMETER_overflow_OutHigh = ovf_q;

`ifdef SC_FREQUENCYMETER_MATCH_EN
  assign SC_FREQUENCYMETER_match_OutHigh = match_q;
`else
  logic unused_match;
  assign unused_match = match_q ^ match_d;
`endif

endmodule

// File: tb/tb_sc_frequencymeter.sv
// Bench for sc_frequencymeter: randomized square waves against a per-window edge-count model.
// Build with SC_FREQUENCYMETER_MATCH_EN defined to also check the match flag.
module tb_sc_frequencymeter;

  localparam int N    = 1000;
  localparam int CW   = 8;
  localparam int FREQ = 50;
  localparam int TOL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig;
  logic [CW-1:0] data;
  logic          valid;
  logic          ovf;
  logic          match;

  always #5 clk = ~clk;

  sc_frequencymeter #(
    .COUNT_WIDTH(CW),
    .GATE_CYCLES(N),
    .FREQUENCY  (FREQ),
    .TOLERANCE  (TOL)
  ) dut (
    .SC_FREQUENCYMETER_CLOCK_50        (clk),
    .SC_FREQUENCYMETER_RESET_InHigh    (rst),
    .SC_FREQUENCYMETER_enable_InHigh   (en),
    .SC_FREQUENCYMETER_signal_In       (sig),
    .SC_FREQUENCYMETER_data_OutBUS     (data),
    .SC_FREQUENCYMETER_valid_OutHigh   (valid),
    .SC_FREQUENCYMETER_overflow_OutHigh(ovf)
`ifdef SC_FREQUENCYMETER_MATCH_EN
    ,
    .SC_FREQUENCYMETER_match_OutHigh   (match)
`endif
  );

`ifndef SC_FREQUENCYMETER_MATCH_EN
  assign match = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int per   = 0;
  int hi    = 0;
  int ph    = 0;
  int edges = 0;

  logic [CW-1:0] dq[$];
  logic          oq[$];
  logic          mq[$];
  int            tq[$];
  int            eq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag,
                         input logic [31:0] obs,
                         input int lo,
                         input int hi_b);
    tests++;
    assert ((obs >= lo && obs <= hi_b) === 1'b1) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d",
             tag, obs, lo, hi_b);
    end
  endtask

  task automatic chk_m(input string tag,
                       input logic obs,
                       input logic exp);
`ifdef SC_FREQUENCYMETER_MATCH_EN
    chk(tag, {31'd0, obs}, {31'd0, exp});
`endif
  endtask

  // one clock: sample outputs just after the edge, then advance the wave
  task automatic tick();
    logic nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      dq.push_back(data);
      oq.push_back(ovf);
      mq.push_back(match);
      tq.push_back(cyc);
      eq.push_back(edges);
    end
    if (per > 0) begin
      ph  = (ph + 1) % per;
      nxt = (ph < hi);
      if (nxt && !sig) edges++;
      sig = nxt;
    end
  endtask

  task automatic set_wave(input int p);
    per = p;
    hi  = int'($urandom_range(p - 1, 1));
    ph  = int'($urandom_range(p - 1, 0));
  endtask

  task automatic get_win(output logic [CW-1:0] d,
                         output logic o,
                         output logic m,
                         output int t,
                         output int e);
    int n = 0;
    d = 'x; o = 1'bx; m = 1'bx; t = -1; e = 0;
    while (dq.size() == 0 && n < N + 200) begin
      tick();
      n++;
    end
    tests++;
    assert (dq.size() != 0) else begin
      fails++;
      $error("FAIL valid_timeout observed=none expected=pulse");
    end
    if (dq.size() != 0) begin
      d = dq.pop_front();
      o = oq.pop_front();
      m = mq.pop_front();
      t = tq.pop_front();
      e = eq.pop_front();
    end
  endtask

  task automatic skip_win();
    logic [CW-1:0] d;
    logic o, m;
    int t, e;
    get_win(d, o, m, t, e);
  endtask

  initial begin
    logic [CW-1:0] d;
    logic o, m;
    int t, e, tp, e0, c0, sum, p, lo, hb;

    rst = 1'b1; en = 1'b0; sig = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk_m("rst_match", match, 1'b0);

    // period 20: exact 50 per window, pulses N apart
    set_wave(20);
    en = 1'b1;
    c0 = cyc;
    get_win(d, o, m, t, e);
    chk("first_latency", t - c0, 1 + N);
    tp = t;
    for (int i = 0; i < 3; i++) begin
      get_win(d, o, m, t, e);
      chk("p20_spacing", t - tp, N);
      chk("p20_data", {24'd0, d}, 50);
      chk("p20_ovf", {31'd0, o}, 0);
      chk_m("p20_match", m, 1'b1);
      tp = t;
    end

    // period 7: 142/143 each, sum tracks driven edges
    set_wave(7);
    skip_win();
    get_win(d, o, m, t, e0);
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      get_win(d, o, m, t, e);
      chk_rng("p7_data", {24'd0, d}, 142, 143);
      sum += int'(d);
    end
    chk_rng("p7_sum", sum, e - e0 - 1, e - e0 + 1);

    // period 2: saturation, then recovery
    set_wave(2);
    skip_win();
    get_win(d, o, m, t, e);
    chk("sat_data", {24'd0, d}, 255);
    chk("sat_ovf", {31'd0, o}, 1);
    chk_m("sat_match", m, 1'b0);
    set_wave(20);
    skip_win();
    get_win(d, o, m, t, e);
    chk("recov_data", {24'd0, d}, 50);
    chk("recov_ovf", {31'd0, o}, 0);
    chk_m("recov_match", m, 1'b1);

    // abort at cycle 600 of a window
    repeat (600) tick();
    en = 1'b0;
    repeat (1200) tick();
    chk("abort_no_valid", dq.size(), 0);
    chk("abort_data", {24'd0, data}, 50);
    chk("abort_ovf", {31'd0, ovf}, 0);
    chk_m("abort_match", match, 1'b1);
    en = 1'b1;
    c0 = cyc;
    get_win(d, o, m, t, e);
    chk("reen_latency", t - c0, 1 + N);
    chk("reen_data", {24'd0, d}, 50);

    // enable low only on the final window cycle
    repeat (N - 1) tick();
    en = 1'b0;
    get_win(d, o, m, tp, e);
    chk("lastcyc_latency", tp - t, N);
    chk("lastcyc_data", {24'd0, d}, 50);
    repeat (1500) tick();
    chk("idle_no_valid", dq.size(), 0);

    // input held high through reset: no false edge
    rst = 1'b1; per = 0; sig = 1'b1; en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      get_win(d, o, m, t, e);
      chk("high_data", {24'd0, d}, 0);
      chk("high_ovf", {31'd0, o}, 0);
    end

    // reset mid-window
    set_wave(20);
    skip_win();
    get_win(d, o, m, t, e);
    chk("prerst_data", {24'd0, d}, 50);
    repeat (500) tick();
    rst = 1'b1;
    tick();
    chk("mrst_data", {24'd0, data}, 0);
    chk("mrst_valid", {31'd0, valid}, 0);
    chk("mrst_ovf", {31'd0, ovf}, 0);
    chk_m("mrst_match", match, 1'b0);
    chk("mrst_no_valid", dq.size(), 0);
    repeat (2) tick();
    rst = 1'b0;
    skip_win();

    // period 22 then random periods against floor/ceil model
    for (int i = 0; i < 6; i++) begin
      p = (i == 0) ? 22 : int'($urandom_range(60, 4));
      set_wave(p);
      skip_win();
      get_win(d, o, m, t, e);
      lo = N / p;
      hb = (N + p - 1) / p;
      chk_rng($sformatf("rand_p%0d_data", p), {24'd0, d}, lo, hb);
      chk($sformatf("rand_p%0d_ovf", p), {31'd0, o}, 0);
      chk_m($sformatf("rand_p%0d_match", p), m,
            (int'(d) >= FREQ - TOL) && (int'(d) <= FREQ + TOL));
    end

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
